// File: rtl/sd_cmd_card_responder_pkg.sv
// ============================================================================
// Module : sd_cmd_card_responder_pkg
// Brief  : Shared CMD-line definitions: frame layout, CRC7, FSM encodings.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_cmd_card_responder_pkg;

  localparam int FRAME_BITS = 48;
  localparam int CRC_BITS   = 40;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int START_POS = 47;
  localparam int TX_POS    = 46;
  localparam int INDEX_MSB = 45;
  localparam int INDEX_LSB = 40;
  localparam int ARG_MSB   = 39;
  localparam int ARG_LSB   = 8;
  localparam int CRC_MSB   = 7;
  localparam int CRC_LSB   = 1;
  localparam int END_POS   = 0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RX   = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_TX   = 2'd3;

  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_crc7.sv
// ============================================================================
// Module : sd_crc7
// Brief  : Serial CRC7 (x^7+x^3+1); clear with enable seeds from zero.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_crc7
  import sd_cmd_card_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= crc7_next(clear ? 7'h00 : crc, bit_in);
    end else if (clear) begin
      crc <= 7'h00;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sd_cmd_card_responder.sv
// ============================================================================
// Module : sd_cmd_card_responder
// Brief  : Card-side CMD engine: receives 48-bit commands, answers with R1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_cmd_card_responder
  import sd_cmd_card_responder_pkg::*;
#(
  parameter int NCR       = 2,
  parameter int FRAME_LEN = FRAME_BITS
)
(
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  input  logic [5:0]  resp_index,
  input  logic [31:0] resp_arg,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index_out,
  output logic [31:0] cmd_arg_out,
  output logic        crc_error,
  output logic        busy
);

  localparam logic [5:0] c_last_bit  = 6'(FRAME_LEN - 1);
  localparam logic [5:0] c_frame_len = 6'(FRAME_LEN);
  localparam logic [5:0] c_crc_bits  = 6'(CRC_BITS);
  localparam logic [5:0] c_ncr_last  = 6'(NCR - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_idle_q;
  logic [5:0]             r_bitcnt;
  logic [5:0]             r_ncr_cnt;
  logic [FRAME_LEN-2:0]   r_rx_shift;
  logic [FRAME_LEN-1:0]   r_tx_shift;
  logic                   r_cmd_valid;
  logic                   r_crc_error;
  logic [5:0]             r_cmd_index;
  logic [31:0]            r_cmd_arg;

  logic [FRAME_LEN-1:0]   w_rx_frame;
  logic [6:0]             w_rx_crc;
  logic [6:0]             w_tx_crc;
  logic                   w_start;
  logic                   w_rx_last;
  logic                   w_frame_ok;
  logic                   w_rx_crc_en;
  logic                   w_tx_crc_clr;
  logic                   w_tx_crc_en;

  // r_idle_q masks the first IDLE cycle so a start bit there is not taken
  assign w_start    = enable && (r_state == ST_IDLE) && r_idle_q && !cmd_in;
  assign w_rx_frame = {r_rx_shift, cmd_in};
  assign w_rx_last  = (r_state == ST_RX) && (r_bitcnt == c_last_bit);
  assign w_frame_ok = !w_rx_frame[START_POS] && w_rx_frame[TX_POS] &&
                      w_rx_frame[END_POS] &&
                      (w_rx_frame[CRC_MSB:CRC_LSB] == w_rx_crc);

  // RX counter holds bits already received, so the arriving bit is bitcnt+1
  assign w_rx_crc_en  = w_start || ((r_state == ST_RX) && (r_bitcnt < c_crc_bits));
  assign w_tx_crc_clr = (r_state == ST_TX) && (r_bitcnt == 6'd1);
  assign w_tx_crc_en  = (r_state == ST_TX) && (r_bitcnt <= c_crc_bits);

  sd_crc7 u_rx_crc (
    .clk    (sd_clock),
    .rst    (reset),
    .clear  (w_start),
    .enable (w_rx_crc_en),
    .bit_in (cmd_in),
    .crc    (w_rx_crc)
  );

  sd_crc7 u_tx_crc (
    .clk    (sd_clock),
    .rst    (reset),
    .clear  (w_tx_crc_clr),
    .enable (w_tx_crc_en),
    .bit_in (r_tx_shift[FRAME_LEN-1]),
    .crc    (w_tx_crc)
  );

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) w_next_state = ST_RX;
        ST_RX:   if (w_rx_last) w_next_state = w_frame_ok ? ST_WAIT : ST_IDLE;
        ST_WAIT: if (r_ncr_cnt == c_ncr_last) w_next_state = ST_TX;
        ST_TX:   if (r_bitcnt == c_frame_len) w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (r_state != ST_IDLE);
    cmd_oe  = (r_state == ST_TX);
    cmd_out = (r_state == ST_TX) ? r_tx_shift[FRAME_LEN-1] : 1'b1;
  end

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      r_idle_q    <= 1'b1;
      r_bitcnt    <= 6'd0;
      r_ncr_cnt   <= 6'd0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '1;
      r_cmd_valid <= 1'b0;
      r_crc_error <= 1'b0;
      r_cmd_index <= 6'd0;
      r_cmd_arg   <= 32'd0;
    end else begin
      r_idle_q    <= (r_state == ST_IDLE);
      r_cmd_valid <= enable && w_rx_last && w_frame_ok;
      r_crc_error <= enable && w_rx_last && !w_frame_ok;

      if (enable && w_rx_last && w_frame_ok) begin
        r_cmd_index <= w_rx_frame[INDEX_MSB:INDEX_LSB];
        r_cmd_arg   <= w_rx_frame[ARG_MSB:ARG_LSB];
      end

      if (w_start || (r_state == ST_RX)) begin
        r_rx_shift <= w_rx_frame[FRAME_LEN-2:0];
      end

      r_ncr_cnt <= (r_state == ST_WAIT) ? r_ncr_cnt + 6'd1 : 6'd0;

      case (r_state)
        ST_IDLE: if (w_start) r_bitcnt <= 6'd1;
        ST_RX:   r_bitcnt <= r_bitcnt + 6'd1;
        ST_WAIT: r_bitcnt <= 6'd1;
        ST_TX:   r_bitcnt <= r_bitcnt + 6'd1;
        default: r_bitcnt <= 6'd0;
      endcase

      // Response fields are captured on the first WAIT edge; CRC slot filled after bit 40
      if ((r_state == ST_WAIT) && (r_ncr_cnt == 6'd0)) begin
        r_tx_shift <= {2'b00, resp_index, resp_arg, 7'h00, 1'b1};
      end else if (r_state == ST_TX) begin
        if (r_bitcnt == c_crc_bits) begin
          r_tx_shift <= {crc7_next(w_tx_crc, r_tx_shift[FRAME_LEN-1]),
                         r_tx_shift[CRC_BITS-1:0], 1'b1};
        end else begin
          r_tx_shift <= {r_tx_shift[FRAME_LEN-2:0], 1'b1};
        end
      end
    end
  end

  assign cmd_valid     = r_cmd_valid;
  assign crc_error     = r_crc_error;
  assign cmd_index_out = r_cmd_index;
  assign cmd_arg_out   = r_cmd_arg;

endmodule

`default_nettype wire

// File: tb/tb_sd_cmd_card_responder.sv
// ============================================================================
// Module : tb_sd_cmd_card_responder
// Brief  : Directed bench for the card CMD responder (NCR=2 and NCR=5 copies).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_cmd_card_responder;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cmd_in;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;

  logic        out2, oe2, valid2, err2, busy2;
  logic [5:0]  idx2;
  logic [31:0] arg2;
  logic        out5, oe5, valid5, err5, busy5;
  logic [5:0]  idx5;
  logic [31:0] arg5;

  int total = 0;
  int bad   = 0;
  int n_valid2 = 0, n_err2 = 0, n_both = 0, n_oe2 = 0;

  sd_cmd_card_responder #(.NCR(2), .FRAME_LEN(48)) dut2 (
    .sd_clock(clk), .reset(reset), .enable(enable), .cmd_in(cmd_in),
    .cmd_out(out2), .cmd_oe(oe2), .resp_index(resp_index), .resp_arg(resp_arg),
    .cmd_valid(valid2), .cmd_index_out(idx2), .cmd_arg_out(arg2),
    .crc_error(err2), .busy(busy2)
  );

  sd_cmd_card_responder #(.NCR(5), .FRAME_LEN(48)) dut5 (
    .sd_clock(clk), .reset(reset), .enable(enable), .cmd_in(cmd_in),
    .cmd_out(out5), .cmd_oe(oe5), .resp_index(resp_index), .resp_arg(resp_arg),
    .cmd_valid(valid5), .cmd_index_out(idx5), .cmd_arg_out(arg5),
    .crc_error(err5), .busy(busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid2) n_valid2++;
    if (err2) n_err2++;
    if (valid2 && err2) n_both++;
    if (oe2) n_oe2++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives all 48 bits; returns 1 time unit after the edge that samples the end bit
  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      cmd_in = f[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_in = 1'b1;
    end
  endtask

  // Latency in cycles from the end-bit edge, then the 48 bits the card drove
  task automatic capture(input logic sel, output int lat, output logic [47:0] fr,
                         output int gaps, output logic [2:0] post);
    lat  = 0;
    gaps = 0;
    fr   = '0;
    while (!(sel ? oe5 : oe2) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int i = 47; i >= 0; i--) begin
      fr[i] = sel ? out5 : out2;
      if (!(sel ? oe5 : oe2)) gaps++;
      @(posedge clk);
      #1;
    end
    post = sel ? {oe5, out5, busy5} : {oe2, out2, busy2};
  endtask

  int          lat;
  int          gaps;
  int          snap_err, snap_oe, snap_pulse;
  logic [47:0] fr;
  logic [2:0]  post;

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    cmd_in     = 1'b1;
    resp_index = 6'd0;
    resp_arg   = 32'd0;

    #1;
    check("reset_ctrl", 64'({out2, oe2, valid2, err2, busy2}), 64'b10000);
    check("reset_index", 64'(idx2), 64'd0);
    check("reset_arg", 64'(arg2), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(4);

    // CMD0 with an all-zero response; CRC of 40 zero bits is zero
    send_frame(48'h40_0000_0000_95);
    check("cmd0_valid", 64'({valid2, err2, busy2}), 64'b101);
    check("cmd0_index", 64'(idx2), 64'd0);
    check("cmd0_arg", 64'(arg2), 64'd0);
    capture(1'b0, lat, fr, gaps, post);
    check("cmd0_latency", 64'(lat), 64'd2);
    check("cmd0_resp", 64'(fr), 64'h00_0000_0000_01);
    check("cmd0_oe_gaps", 64'(gaps), 64'd0);
    check("cmd0_post", 64'(post), 64'b010);
    idle(20);

    // CMD8
    send_frame(48'h48_0000_01AA_87);
    check("cmd8_pulses", 64'({valid2, err2}), 64'b10);
    check("cmd8_index", 64'(idx2), 64'd8);
    check("cmd8_arg", 64'(arg2), 64'h0000_01AA);
    idle(70);

    // CMD17 with R1 payload 0x900
    resp_index = 6'd17;
    resp_arg   = 32'h0000_0900;
    send_frame(48'h51_0000_0000_55);
    check("cmd17_index", 64'(idx2), 64'd17);
    check("cmd17_arg", 64'(arg2), 64'd0);
    capture(1'b0, lat, fr, gaps, post);
    check("cmd17_latency", 64'(lat), 64'd2);
    check("cmd17_resp", 64'(fr), 64'h11_0000_0900_67);
    check("cmd17_oe_gaps", 64'(gaps), 64'd0);
    idle(20);

    // Bad end bit; cmd_in stays low into the re-entry cycle, which must be ignored
    snap_err = n_err2;
    snap_oe  = n_oe2;
    send_frame(48'h48_0000_01AA_86);
    check("endbit_pulses", 64'({valid2, err2, busy2}), 64'b010);
    @(posedge clk);
    #1;
    check("reentry_ignored_busy", 64'(busy2), 64'd0);
    idle(60);
    // CRC LSB flipped
    send_frame(48'h48_0000_01AA_85);
    check("crcbad_pulses", 64'({valid2, err2, busy2}), 64'b010);
    check("crcbad_index_held", 64'(idx2), 64'd17);
    idle(60);
    check("bad_frames_err_count", 64'(n_err2 - snap_err), 64'd2);
    check("bad_frames_no_oe", 64'(n_oe2 - snap_oe), 64'd0);

    // Async reset in the middle of the response
    resp_index = 6'd0;
    resp_arg   = 32'd0;
    send_frame(48'h40_0000_0000_95);
    lat = 0;
    while (!oe2 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rst_pre_latency", 64'(lat), 64'd2);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    check("rst_pre_oe", 64'(oe2), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_pin", 64'({oe2, out2, busy2}), 64'b010);
    check("rst_async_arg", 64'(arg2), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(4);
    send_frame(48'h48_0000_01AA_87);
    check("after_rst_cmd8", 64'({valid2, idx2, arg2}), {1'b1, 6'd8, 32'h0000_01AA});
    capture(1'b0, lat, fr, gaps, post);
    check("after_rst_latency", 64'(lat), 64'd2);
    check("after_rst_resp", 64'(fr), 64'h00_0000_0000_01);
    idle(70);

    // Enable drops after RX bit 30
    snap_pulse = n_valid2 + n_err2;
    fr = 48'h40_0000_0000_95;
    for (int i = 47; i >= 18; i--) begin
      @(negedge clk);
      cmd_in = fr[i];
    end
    @(posedge clk);
    #1;
    check("en_drop_rx_busy", 64'({busy2, busy5}), 64'b11);
    @(negedge clk);
    enable = 1'b0;
    cmd_in = 1'b1;
    @(posedge clk);
    #1;
    check("en_drop_idle", 64'({busy2, busy5, oe2}), 64'b000);
    idle(60);
    check("en_drop_no_pulse", 64'(n_valid2 + n_err2 - snap_pulse), 64'd0);
    enable = 1'b1;
    idle(4);

    // NCR=5 copy answering CMD17
    resp_index = 6'd17;
    resp_arg   = 32'h0000_0900;
    send_frame(48'h51_0000_0000_55);
    check("ncr5_valid", 64'({valid5, err5, idx5}), {1'b1, 1'b0, 6'd17});
    capture(1'b1, lat, fr, gaps, post);
    check("ncr5_latency", 64'(lat), 64'd5);
    check("ncr5_resp", 64'(fr), 64'h11_0000_0900_67);
    check("ncr5_post", 64'(post), 64'b010);
    check("ncr5_arg_held", 64'(arg5), 64'd0);
    idle(10);

    check("never_both_pulses", 64'(n_both), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
